// File: rtl/wb_arbiter_pkg.sv
// Shared core constants for the writeback arbiter: widths, source indices and
// the round-robin pointer step helper.
package wb_arbiter_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NSRC  = 3;
   localparam int unsigned REG_W = 5;

   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_LSU = 2'd1;
   localparam logic [1:0] SRC_MDU = 2'd2;

   // Next source index in round-robin order, wrapping MDU back to ALU.
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx == SRC_MDU) ? SRC_ALU : idx + 2'd1;
   endfunction

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Three-way round-robin arbiter: one-hot grant out of the valid vector, with
// the last-granted pointer held internally. Grant is suppressed during reset.
module rr_arbiter
   import wb_arbiter_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic [NSRC-1:0] valid,
   output logic [NSRC-1:0] grant
);

   logic [1:0] last;
   logic [1:0] cand;
   logic [1:0] gidx;
   logic       found;

   // Search starts just after the last winner, so every source waits at most
   // two cycles behind the others.
   always_comb begin
      grant = '0;
      found = 1'b0;
      gidx  = last;
      cand  = rr_next(last);
      for (int unsigned k = 0; k < NSRC; k++) begin
         if (!found && reset && valid[cand]) begin
            grant[cand] = 1'b1;
            gidx        = cand;
            found       = 1'b1;
         end
         cand = rr_next(cand);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         last <= SRC_MDU;
      end else if (found) begin
         last <= gidx;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU/LSU/MDU results into the single register-file
// write port via a one-deep output register. Optional counters: WB_PERF_EN.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned XLEN = wb_arbiter_pkg::XLEN,
   parameter int unsigned NSRC = wb_arbiter_pkg::NSRC
)
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NSRC-1:0]      src_valid,
   output logic [NSRC-1:0]      src_ready,
   input  logic [NSRC*5-1:0]    src_rd,
   input  logic [NSRC-1:0]      src_rf_wen,
   input  logic [NSRC*XLEN-1:0] src_wdata,
   output logic                 rf_wen,
   output logic [4:0]           rf_waddr,
   output logic [XLEN-1:0]      rf_wdata,
   output logic [4:0]           wb_rd,
   output logic                 wb_rf_wen,
   output logic                 wb_valid
`ifdef WB_PERF_EN
   ,
   output logic [63:0]          instret,
   output logic [NSRC*32-1:0]   src_retired
`endif
);

   logic [NSRC-1:0]  grant;
   logic [REG_W-1:0] sel_rd;
   logic             sel_wen;
   logic [XLEN-1:0]  sel_data;

   rr_arbiter u_rr (
      .clock (clock),
      .reset (reset),
      .valid (src_valid),
      .grant (grant)
   );

   assign src_ready = grant;

   always_comb begin
      sel_rd   = '0;
      sel_wen  = 1'b0;
      sel_data = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (grant[i]) begin
            sel_rd   = src_rd[i*REG_W +: REG_W];
            sel_wen  = src_rf_wen[i];
            sel_data = src_wdata[i*XLEN +: XLEN];
         end
      end
   end

   // x0 still retires but never raises the write/release strobe.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wb_valid <= 1'b0;
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         wb_valid <= |grant;
         rf_wen   <= sel_wen && (sel_rd != '0);
         rf_waddr <= sel_rd;
         rf_wdata <= sel_data;
      end
   end

   assign wb_rd     = rf_waddr;
   assign wb_rf_wen = rf_wen;

`ifdef WB_PERF_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         instret     <= '0;
         src_retired <= '0;
      end else begin
         if (wb_valid) begin
            instret <= instret + 64'd1;
         end
         for (int unsigned i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
               src_retired[i*32 +: 32] <= src_retired[i*32 +: 32] + 32'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, reset corner case
// and a random run, all checked through an expected-output queue.
module tb_wb_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [2:0]  src_valid;
   logic [2:0]  src_ready;
   logic [14:0] src_rd;
   logic [2:0]  src_rf_wen;
   logic [95:0] src_wdata;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  wb_rd;
   logic        wb_rf_wen;
   logic        wb_valid;
`ifdef WB_PERF_EN
   logic [63:0] instret;
   logic [95:0] src_retired;
   logic [63:0] exp_instret;
   logic [31:0] exp_ret [3];
`endif

   wb_arbiter #(.XLEN(32), .NSRC(3)) dut (
      .clock      (clock),
      .reset      (reset),
      .src_valid  (src_valid),
      .src_ready  (src_ready),
      .src_rd     (src_rd),
      .src_rf_wen (src_rf_wen),
      .src_wdata  (src_wdata),
      .rf_wen     (rf_wen),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .wb_rd      (wb_rd),
      .wb_rf_wen  (wb_rf_wen),
      .wb_valid   (wb_valid)
`ifdef WB_PERF_EN
      ,
      .instret    (instret),
      .src_retired(src_retired)
`endif
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        v;
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] data;
   } out_t;

   typedef struct packed {
      logic [2:0]  valid;
      logic [14:0] rd;
      logic [2:0]  wen;
      logic [31:0] base;
      logic [2:0]  exp_grant;
      logic        exp_wen;
      logic [4:0]  exp_rd;
   } vec_t;

   out_t        sb[$];
   int unsigned tests  = 0;
   int unsigned failed = 0;
   logic [1:0]  mlast;
   int unsigned exp_cnt [32];
   int unsigned act_cnt [32];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] model_grant(input logic [2:0] v, input logic [1:0] last);
      int unsigned idx;
      for (int unsigned k = 1; k <= 3; k++) begin
         idx = (int'(last) + k) % 3;
         if (v[idx]) return 3'b001 << idx;
      end
      return 3'b000;
   endfunction

   function automatic int unsigned onehot_idx(input logic [2:0] g);
      for (int unsigned i = 0; i < 3; i++) if (g[i]) return i;
      return 0;
   endfunction

   // Drive one cycle of stimulus, check the combinational grant, queue the
   // expected registered output, then clock and compare against the queue head.
   task automatic drive_cycle(input logic [2:0] v, input logic [14:0] rd, input logic [2:0] wen,
                              input logic [31:0] base, input logic [2:0] eg, input out_t e);
      out_t got;
      src_valid  = v;
      src_rd     = rd;
      src_rf_wen = wen;
      for (int unsigned i = 0; i < 3; i++) src_wdata[i*32 +: 32] = base + i;
      #1;
      chk("src_ready", {61'd0, src_ready}, {61'd0, eg});
      sb.push_back(e);
      if (eg != 3'b000) mlast = 2'(onehot_idx(eg));
`ifdef WB_PERF_EN
      if (eg != 3'b000) exp_ret[onehot_idx(eg)]++;
`endif
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 64'd1, 64'd0);
      end else begin
         got = sb.pop_front();
         chk("wb_valid", {63'd0, wb_valid}, {63'd0, got.v});
         chk("rf_wen", {63'd0, rf_wen}, {63'd0, got.wen});
         chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, got.rd});
         chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, got.data});
         chk("wb_rd", {59'd0, wb_rd}, {59'd0, got.rd});
         chk("wb_rf_wen", {63'd0, wb_rf_wen}, {63'd0, got.wen});
`ifdef WB_PERF_EN
         chk("instret", instret, exp_instret);
         if (got.v) exp_instret++;
         for (int unsigned i = 0; i < 3; i++)
            chk("src_retired", {32'd0, src_retired[i*32 +: 32]}, {32'd0, exp_ret[i]});
`endif
      end
      if (wb_rf_wen) act_cnt[wb_rd]++;
   endtask

   function automatic out_t make_exp(input logic [2:0] eg, input logic [14:0] rd,
                                     input logic [2:0] wen, input logic [31:0] base);
      out_t e;
      int unsigned i;
      e = '0;
      if (eg != 3'b000) begin
         i      = onehot_idx(eg);
         e.v    = 1'b1;
         e.rd   = rd[i*5 +: 5];
         e.wen  = wen[i] && (rd[i*5 +: 5] != 5'd0);
         e.data = base + i;
      end
      return e;
   endfunction

   vec_t tbl [12];

   initial begin
      out_t        e;
      logic [2:0]  v, w, eg;
      logic [14:0] r;
      logic [31:0] b;

      // valid, rd {MDU,LSU,ALU}, wen, data base, expected grant/wen/rd
      tbl[0]  = '{3'b001, {5'd0, 5'd0, 5'd5},    3'b001, 32'h1234, 3'b001, 1'b1, 5'd5};
      tbl[1]  = '{3'b010, {5'd0, 5'd0, 5'd0},    3'b010, 32'h2000, 3'b010, 1'b0, 5'd0};
      tbl[2]  = '{3'b100, {5'd7, 5'd0, 5'd0},    3'b000, 32'h3000, 3'b100, 1'b0, 5'd7};
      tbl[3]  = '{3'b000, {5'd1, 5'd2, 5'd3},    3'b111, 32'h4000, 3'b000, 1'b0, 5'd0};
      tbl[4]  = '{3'b111, {5'd3, 5'd2, 5'd1},    3'b111, 32'h5000, 3'b001, 1'b1, 5'd1};
      tbl[5]  = '{3'b111, {5'd6, 5'd5, 5'd4},    3'b101, 32'h6000, 3'b010, 1'b0, 5'd5};
      tbl[6]  = '{3'b111, {5'd9, 5'd8, 5'd0},    3'b111, 32'h7000, 3'b100, 1'b1, 5'd9};
      tbl[7]  = '{3'b110, {5'd12, 5'd11, 5'd10}, 3'b111, 32'h8000, 3'b010, 1'b1, 5'd11};
      tbl[8]  = '{3'b101, {5'd15, 5'd14, 5'd13}, 3'b111, 32'h9000, 3'b100, 1'b1, 5'd15};
      tbl[9]  = '{3'b100, {5'd0, 5'd0, 5'd0},    3'b100, 32'hA000, 3'b100, 1'b0, 5'd0};
      tbl[10] = '{3'b011, {5'd0, 5'd17, 5'd16},  3'b011, 32'hB000, 3'b001, 1'b1, 5'd16};
      tbl[11] = '{3'b011, {5'd0, 5'd19, 5'd18},  3'b010, 32'hC000, 3'b010, 1'b1, 5'd19};

      for (int unsigned i = 0; i < 32; i++) begin
         exp_cnt[i] = 0;
         act_cnt[i] = 0;
      end
`ifdef WB_PERF_EN
      exp_instret = '0;
      for (int unsigned i = 0; i < 3; i++) exp_ret[i] = '0;
`endif

      // Reset with all sources asserting: no grant may leak out.
      reset      = 1'b0;
      src_valid  = 3'b111;
      src_rd     = {5'd3, 5'd2, 5'd1};
      src_rf_wen = 3'b111;
      src_wdata  = {32'hCC, 32'hBB, 32'hAA};
      repeat (3) @(posedge clock);
      #1;
      chk("rst_ready", {61'd0, src_ready}, 64'd0);
      chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
      chk("rst_rf_wen", {63'd0, rf_wen}, 64'd0);
      chk("rst_rf_waddr", {59'd0, rf_waddr}, 64'd0);
      chk("rst_rf_wdata", {32'd0, rf_wdata}, 64'd0);
      chk("rst_wb_rf_wen", {63'd0, wb_rf_wen}, 64'd0);
`ifdef WB_PERF_EN
      chk("rst_instret", instret, 64'd0);
`endif
      reset = 1'b1;
      mlast = 2'd2;

      for (int unsigned i = 0; i < 12; i++) begin
         e = '0;
         if (tbl[i].exp_grant != 3'b000) begin
            e.v    = 1'b1;
            e.wen  = tbl[i].exp_wen;
            e.rd   = tbl[i].exp_rd;
            e.data = tbl[i].base + onehot_idx(tbl[i].exp_grant);
         end
         if (e.wen) exp_cnt[e.rd]++;
         drive_cycle(tbl[i].valid, tbl[i].rd, tbl[i].wen, tbl[i].base, tbl[i].exp_grant, e);
      end

      // Random patterns against the reference round-robin model.
      for (int unsigned n = 0; n < 1000; n++) begin
         v  = 3'($urandom_range(0, 7));
         w  = 3'($urandom_range(0, 7));
         r  = 15'($urandom);
         b  = $urandom;
         eg = model_grant(v, mlast);
         e  = make_exp(eg, r, w, b);
         if (e.wen) exp_cnt[e.rd]++;
         drive_cycle(v, r, w, b, eg, e);
      end

      // Reset right after a grant: the following edge clears the output and
      // the pointer, so the next grant among all-valid goes to ALU.
      e = make_exp(3'b010, {5'd0, 5'd21, 5'd0}, 3'b010, 32'hE000);
      exp_cnt[21]++;
      drive_cycle(3'b010, {5'd0, 5'd21, 5'd0}, 3'b010, 32'hE000, 3'b010, e);
      reset      = 1'b0;
      src_valid  = 3'b111;
      src_rd     = {5'd24, 5'd23, 5'd22};
      src_rf_wen = 3'b111;
      #1;
      chk("midrst_ready", {61'd0, src_ready}, 64'd0);
      @(posedge clock);
      #1;
      chk("midrst_wb_valid", {63'd0, wb_valid}, 64'd0);
      chk("midrst_rf_wen", {63'd0, rf_wen}, 64'd0);
      chk("midrst_rf_waddr", {59'd0, rf_waddr}, 64'd0);
      chk("midrst_rf_wdata", {32'd0, rf_wdata}, 64'd0);
      chk("midrst_wb_rf_wen", {63'd0, wb_rf_wen}, 64'd0);
      reset = 1'b1;
      mlast = 2'd2;
`ifdef WB_PERF_EN
      exp_instret = '0;
      for (int unsigned i = 0; i < 3; i++) exp_ret[i] = '0;
`endif
      e = make_exp(3'b001, {5'd24, 5'd23, 5'd22}, 3'b111, 32'hF000);
      exp_cnt[22]++;
      drive_cycle(3'b111, {5'd24, 5'd23, 5'd22}, 3'b111, 32'hF000, 3'b001, e);
      src_valid = 3'b000;
      @(posedge clock);
      #1;
      chk("drain_wb_valid", {63'd0, wb_valid}, 64'd0);
      chk("sb_leftover", 64'(sb.size()), 64'd0);

      for (int unsigned i = 1; i < 32; i++)
         chk($sformatf("release_count_x%0d", i), 64'(act_cnt[i]), 64'(exp_cnt[i]));
      chk("release_count_x0", 64'(act_cnt[0]), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the pipelined core. It merges completed results from the ALU, LSU and MDU into the single register-file write port, one result per cycle. It produces the writeback release (`wb_rd`/`wb_rf_wen`) that the scoreboard consumes to retire pending destination registers. Sources are granted round-robin, and the write is issued from a one-deep output register.

## Interface
Parameters:
- `XLEN`, 32, register/data width
- `NSRC`, 3, number of result sources (fixed at 3 in this revision: 0=ALU, 1=LSU, 2=MDU)

Ports:
- `clock`  input  1  single clock, all state on rising edge
- `reset`  input  1  synchronous, active-low (state cleared on the rising edge where `reset`==0)
- `src_valid`  input  NSRC  per-source result valid
- `src_ready`  output  NSRC  per-source accept; one-hot or zero
- `src_rd`  input  NSRC*5  per-source destination register, packed, source i at [5i+4:5i]
- `src_rf_wen`  input  NSRC  per-source "writes a register"
- `src_wdata`  input  NSRC*XLEN  per-source result data, packed
- `rf_wen`  output  1  register-file write enable
- `rf_waddr`  output  5  register-file write address
- `rf_wdata`  output  XLEN  register-file write data
- `wb_rd`  output  5  scoreboard release address (equals `rf_waddr`)
- `wb_rf_wen`  output  1  scoreboard release strobe (equals `rf_wen`)
- `wb_valid`  output  1  an instruction retires this cycle, including non-writing ones
- `instret`  output  64  retired-instruction count (only with `WB_PERF_EN`)
- `src_retired`  output  NSRC*32  per-source retire counts (only with `WB_PERF_EN`)

## Operation
- Grant: each cycle, exactly one valid source is granted; `src_ready[i]`=1 only for the granted source. `src_ready` depends combinationally on `src_valid`, and sources must not make `src_valid` depend on `src_ready`.
- Round-robin: `last` is a 2-bit register holding the last granted index, reset to 2. Priority order is `last`+1, `last`+2, `last`+3 mod 3. `last` updates only on a grant.
- Output register: on a grant, latch `wb_valid`=1, `rd`, `wdata`, and `wen` = `src_rf_wen` && `rd`!=0. With no grant, `wb_valid`=0 and `wen`=0.
- Output stage: drains every cycle. The register file never back-pressures, so the arbiter never stalls a grant.
- x0: writes to x0 produce `wb_valid`=1 but `rf_wen`=`wb_rf_wen`=0. This matches the scoreboard, which never counts x0.
- Release: exactly one `wb_rf_wen` pulse is issued per accepted result with `rf_wen` set and `rd`!=0. This guarantees each scoreboard increment is matched by one decrement.
- WAW ordering: the arbiter does not reorder or check same-`rd` writes. Program-order completion for a given `rd` is the issue stage's responsibility.

## Timing
- Latency: a source is accepted in cycle N; `rf_*`/`wb_*` are valid in cycle N+1. Throughput is one result per cycle.
- Reset values: `wb_valid`=0, `rf_wen`=`wb_rf_wen`=0, `rf_waddr`=`wb_rd`=0, `rf_wdata`=0, `last`=2, counters=0. `src_ready`=0 while `reset`==0.
- Reset mid-operation: the output register is cleared, so any result latched but not yet written is dropped. Upstream and the scoreboard reset on the same edge.
- Simultaneous valids: the losers hold `src_valid` and their data stable until granted. Maximum wait is 2 cycles.
- A single valid source is granted in the same cycle regardless of the `last` pointer.

## Configuration
- `WB_PERF_EN` defined:
  - `instret` increments on every cycle with `wb_valid`=1.
  - `src_retired[i]` increments when source i is accepted.
  - Counters wrap modulo 2^64 and 2^32 respectively.
- `WB_PERF_EN` undefined: the counter ports and logic are absent, and the rest of the behaviour is unchanged.

## Structure
- Shared core package: `XLEN`, `NSRC`, source index constants `SRC_ALU`=0, `SRC_LSU`=1, `SRC_MDU`=2, and the register-index width (5).
- Sub-module `rr_arbiter`: holds `valid` in, the one-hot `grant` out, and the internal `last` pointer. Instantiated once.

## Test plan
- ALU only, valid with `rd`=5, data 0x1234, wen=1 -> next cycle `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0x1234, `wb_rf_wen`=1, `wb_valid`=1.
- All three valid continuously from reset -> grants ALU, LSU, MDU, ALU... one per cycle. Each result appears exactly once, in cycles 1..N+1.
- LSU `rd`=0, wen=1 -> `wb_valid`=1, `rf_wen`=0, `wb_rf_wen`=0.
- MDU `rd`=7, `src_rf_wen`=0 (e.g. store-like op) -> `wb_valid`=1, `wb_rf_wen`=0. With `WB_PERF_EN`, `instret` increments by 1.
- Drive `reset`=0 in the cycle after a grant -> next cycle all outputs 0, the dropped result is not written, and the first post-reset grant starts at ALU.
- 1000 random valid/rd/wen patterns checked against a reference model -> `wb_rf_wen` pulses per `rd` equal accepted writing results per `rd`. No result is lost or duplicated.
